// File: rtl/decode_queue.sv
// decode_queue: RV32I+M decoder feeding a DEPTH-entry circular FIFO.
// Fetch pushes {pc, instr} over in_valid/in_ready. The instruction is decoded
// on write, so each queue entry holds a ready-to-use control bundle. Execute
// pops the head over out_valid/out_ready. flush discards every queued entry.
// Optional feature macro: DECODE_ILLEGAL_EN adds the out_illegal port, which
// carries a per-entry flag for undecodable encodings.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic [31:0]              out_imm,
  output logic [14:0]              out_ctrl,
`ifdef DECODE_ILLEGAL_EN
  output logic                     out_illegal,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct7 values accepted on R-type
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Bit positions inside the 15-bit control bundle; alu_ctrl occupies [3:0]
  localparam int C_REG_WRITE  = 14;
  localparam int C_ALU_SRC    = 13;
  localparam int C_MEM_READ   = 12;
  localparam int C_MEM_WRITE  = 11;
  localparam int C_MEM_TO_REG = 10;
  localparam int C_BRANCH     = 9;
  localparam int C_JUMP       = 8;
  localparam int C_JALR       = 7;
  localparam int C_IS_LUI     = 6;
  localparam int C_IS_AUIPC   = 5;
  localparam int C_IS_MULDIV  = 4;

  typedef struct packed {
    logic [31:0] imm;
    logic [14:0] ctrl;
  } dec_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic [14:0]     ctrl;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  // Base ALU operation selected by funct3 alone (no SUB/SRA refinement)
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Full decode of one instruction word into immediate plus control bundle.
  // Anything not recognised stays all-zero, i.e. behaves as a NOP.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t        d;
    logic [3:0]  alu_base;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    d        = '0;
    f3       = instr[14:12];
    f7       = instr[31:25];
    alu_base = alu_from_funct3(f3);
    imm_i    = {{20{instr[31]}}, instr[31:20]};
    imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    imm_u    = {instr[31:12], 12'h000};
    case (instr[6:0])
      OP_R: begin
        if (f7 == F7_MULDIV) begin
          d.ctrl[C_REG_WRITE] = 1'b1;
          d.ctrl[C_IS_MULDIV] = 1'b1;
          d.ctrl[3:0]         = ALU_ADD;
        end else if ((f7 == F7_BASE) || (f7 == F7_ALT)) begin
          d.ctrl[C_REG_WRITE] = 1'b1;
          if (instr[30] && (f3 == 3'b000)) begin
            d.ctrl[3:0] = ALU_SUB;
          end else if (instr[30] && (f3 == 3'b101)) begin
            d.ctrl[3:0] = ALU_SRA;
          end else begin
            d.ctrl[3:0] = alu_base;
          end
        end else begin
          d = '0;
        end
      end
      OP_IMM: begin
        d.ctrl[C_REG_WRITE] = 1'b1;
        d.ctrl[C_ALU_SRC]   = 1'b1;
        d.imm               = imm_i;
        // Immediate forms never subtract; bit 30 only distinguishes SRAI
        if (instr[30] && (f3 == 3'b101)) begin
          d.ctrl[3:0] = ALU_SRA;
        end else begin
          d.ctrl[3:0] = alu_base;
        end
      end
      OP_LOAD: begin
        d.ctrl[C_REG_WRITE]  = 1'b1;
        d.ctrl[C_ALU_SRC]    = 1'b1;
        d.ctrl[C_MEM_READ]   = 1'b1;
        d.ctrl[C_MEM_TO_REG] = 1'b1;
        d.ctrl[3:0]          = ALU_ADD;
        d.imm                = imm_i;
      end
      OP_STORE: begin
        d.ctrl[C_ALU_SRC]   = 1'b1;
        d.ctrl[C_MEM_WRITE] = 1'b1;
        d.ctrl[3:0]         = ALU_ADD;
        d.imm               = imm_s;
      end
      OP_BRANCH: begin
        d.ctrl[C_BRANCH] = 1'b1;
        d.ctrl[3:0]      = ALU_SUB;
        d.imm            = imm_b;
      end
      OP_JAL: begin
        d.ctrl[C_REG_WRITE] = 1'b1;
        d.ctrl[C_JUMP]      = 1'b1;
        d.imm               = imm_j;
      end
      OP_JALR: begin
        d.ctrl[C_REG_WRITE] = 1'b1;
        d.ctrl[C_JALR]      = 1'b1;
        d.ctrl[C_ALU_SRC]   = 1'b1;
        d.imm               = imm_i;
      end
      OP_LUI: begin
        d.ctrl[C_REG_WRITE] = 1'b1;
        d.ctrl[C_IS_LUI]    = 1'b1;
        d.imm               = imm_u;
      end
      OP_AUIPC: begin
        d.ctrl[C_REG_WRITE] = 1'b1;
        d.ctrl[C_IS_AUIPC]  = 1'b1;
        d.imm               = imm_u;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

`ifdef DECODE_ILLEGAL_EN
  // Flags encodings the decoder cannot honour; a low-bit pair other than 2'b11
  // can never match a known opcode and so lands in the default arm.
  function automatic logic is_illegal(input logic [31:0] instr);
    logic ill;
    case (instr[6:0])
      OP_R:      ill = !((instr[31:25] == F7_BASE) || (instr[31:25] == F7_ALT) ||
                         (instr[31:25] == F7_MULDIV));
      OP_IMM,
      OP_LOAD,
      OP_STORE,
      OP_BRANCH,
      OP_JAL,
      OP_JALR,
      OP_LUI,
      OP_AUIPC:  ill = 1'b0;
      default:   ill = 1'b1;
    endcase
    return ill;
  endfunction
`endif

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  entry_t           mem_r [DEPTH];

  logic   full_s;
  logic   empty_s;
  logic   push_s;
  logic   pop_s;
  dec_t   dec_s;
  entry_t wr_entry_s;
  entry_t head_s;

  // Occupancy flags and handshake qualifiers
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
    push_s  = in_valid && !full_s;
    pop_s   = out_ready && !empty_s;
  end

  // Decode the offered instruction into the entry that would be written
  always_comb begin
    dec_s             = decode_instr(in_instr);
    wr_entry_s        = '0;
    wr_entry_s.pc     = in_pc;
    wr_entry_s.rd     = in_instr[11:7];
    wr_entry_s.rs1    = in_instr[19:15];
    wr_entry_s.rs2    = in_instr[24:20];
    wr_entry_s.funct3 = in_instr[14:12];
    wr_entry_s.imm    = dec_s.imm;
    wr_entry_s.ctrl   = dec_s.ctrl;
`ifdef DECODE_ILLEGAL_EN
    wr_entry_s.illegal = is_illegal(in_instr);
`endif
  end

  // Pointer and occupancy state; flush wins over any push or pop that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are left as-is by reset and flush
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Head entry, forced to zero while the queue is empty
  always_comb begin
    head_s = '0;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign in_ready   = !full_s;
  assign out_valid  = !empty_s;
  assign count      = count_r;
  assign out_pc     = head_s.pc;
  assign out_rd     = head_s.rd;
  assign out_rs1    = head_s.rs1;
  assign out_rs2    = head_s.rs2;
  assign out_funct3 = head_s.funct3;
  assign out_imm    = head_s.imm;
  assign out_ctrl   = head_s.ctrl;
`ifdef DECODE_ILLEGAL_EN
  assign out_illegal = head_s.illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference with its own decoder.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  // funct3 -> ALU code: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [3:0] F3_ALU [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  localparam logic [6:0] OPCODES [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                          7'h6F, 7'h67, 7'h37, 7'h17};
  localparam logic [31:0] FILL_INSTR [5] = '{32'h00500113, 32'h002081B3, 32'h0000A203,
                                             32'h0040A023, 32'hFE208EE3};

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [2:0]        out_funct3;
  logic [31:0]       out_imm;
  logic [14:0]       out_ctrl;
`ifdef DECODE_ILLEGAL_EN
  logic              out_illegal;
`endif
  logic [$clog2(DEPTH):0] count;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_ctrl(out_ctrl),
`ifdef DECODE_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [14:0] ctrl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written per instruction class from the ISA rules
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    logic rw, as, mr, mw, m2r, br, j, jr, lui, auipc, md;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0;
    {rw, as, mr, mw, m2r, br, j, jr, lui, auipc, md} = 11'd0;
    alu = 4'd0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = f3;
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h01) begin
          rw = 1'b1; md = 1'b1;
        end else if (f7 == 7'h00 || f7 == 7'h20) begin
          rw = 1'b1;
          alu = F3_ALU[f3];
          if (ins[30] && f3 == 3'd0) alu = 4'd1;
          if (ins[30] && f3 == 3'd5) alu = 4'd7;
        end else begin
          e.ill = 1'b1;
        end
      end
      7'h13: begin
        rw = 1'b1; as = 1'b1; alu = F3_ALU[f3];
        if (ins[30] && f3 == 3'd5) alu = 4'd7;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h03: begin
        rw = 1'b1; as = 1'b1; mr = 1'b1; m2r = 1'b1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h23: begin
        as = 1'b1; mw = 1'b1;
        e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'h63: begin
        br = 1'b1; alu = 4'd1;
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h6F: begin
        rw = 1'b1; j = 1'b1;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        rw = 1'b1; jr = 1'b1; as = 1'b1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h37: begin rw = 1'b1; lui = 1'b1;   e.imm = ins & 32'hFFFFF000; end
      7'h17: begin rw = 1'b1; auipc = 1'b1; e.imm = ins & 32'hFFFFF000; end
      default: e.ill = 1'b1;
    endcase
    e.ctrl = {rw, as, mr, mw, m2r, br, j, jr, lui, auipc, md, alu};
    return e;
  endfunction

  task automatic verify();
    exp_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    check("count", 64'(count), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_pc", 64'(out_pc), 64'(h.pc));
    check("out_rd", 64'(out_rd), 64'(h.rd));
    check("out_rs1", 64'(out_rs1), 64'(h.rs1));
    check("out_rs2", 64'(out_rs2), 64'(h.rs2));
    check("out_funct3", 64'(out_funct3), 64'(h.f3));
    check("out_imm", 64'(out_imm), 64'(h.imm));
    check("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
`ifdef DECODE_ILLEGAL_EN
    check("out_illegal", 64'(out_illegal), 64'(h.ill));
`else
    if (h.ill) check("illegal_nop", 64'(out_ctrl), 64'd0);
`endif
  endtask

  // One clock: predict the effect of the current inputs, then compare
  task automatic cycle();
    exp_t e;
    bit   push, pop;
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() > 0);
    e    = model(in_pc, in_instr);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    verify();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) begin
      w[6:0] = OPCODES[k];
      if (k == 0) begin
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: w[31:25] = 7'($urandom);
        endcase
      end
      if (k == 1 && w[14:12] == 3'd5) w[31:25] = {1'b0, w[30], 5'd0};
    end
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #12;
    verify();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // ADDI x1,x0,-5
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hFFB00093;
    cycle();
    in_valid = 1'b0;
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_regwrite", 64'(out_ctrl[14]), 64'd1);
    check("addi_alusrc", 64'(out_ctrl[13]), 64'd1);
    check("addi_alu", 64'(out_ctrl[3:0]), 64'd0);
    check("addi_imm", 64'(out_imm), 64'hFFFFFFFB);
    check("addi_rd", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Five pushes against a stalled consumer
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_instr = FILL_INSTR[i];
      cycle();
    end
    in_valid = 1'b0;
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(out_pc), 64'(32'h200 + 32'(4 * i)));
      cycle();
    end
    check("drained_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Full queue: simultaneous offer and consume only pops
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i); in_instr = FILL_INSTR[i];
      cycle();
    end
    in_pc = 32'h340; in_instr = FILL_INSTR[4]; out_ready = 1'b1;
    cycle();
    check("full_pop_count", 64'(count), 64'd3);
    out_ready = 1'b0;
    cycle();
    check("refill_count", 64'(count), 64'd4);
    in_valid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Flush with three queued and a push in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i); in_instr = FILL_INSTR[i];
      cycle();
    end
    flush = 1'b1; in_pc = 32'h40C; in_instr = FILL_INSTR[3];
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);

    // MUL, SRAI, SUB decode through the head
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h022081B3;
    cycle();
    check("mul_muldiv", 64'(out_ctrl[4]), 64'd1);
    check("mul_funct3", 64'(out_funct3), 64'd0);
    out_ready = 1'b1; in_pc = 32'h504; in_instr = 32'h4020D093;
    cycle();
    check("srai_alu", 64'(out_ctrl[3:0]), 64'd7);
    in_pc = 32'h508; in_instr = 32'h402081B3;
    cycle();
    check("sub_alu", 64'(out_ctrl[3:0]), 64'd1);
    in_valid = 1'b0;
    cycle();

    // Unknown opcode
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'h0000007F;
    cycle();
    in_valid = 1'b0;
    check("illegal_ctrl", 64'(out_ctrl), 64'd0);
`ifdef DECODE_ILLEGAL_EN
    check("illegal_flag", 64'(out_illegal), 64'd1);
`endif

    // Asynchronous reset in the middle of traffic
    in_valid = 1'b1; in_pc = 32'h700; in_instr = FILL_INSTR[1];
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    q.delete();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    verify();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_pc     = $urandom;
      in_instr  = rand_instr();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
